// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared memory port and drives the shared-ALU datapath selects and enables.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       IllegalOp,
  output logic [3:0] StateOut
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t     state;
  state_t     next_state;
  ctrl_t      ctrl;
  logic       supported;

  // Moore control word for a state; registered from next_state so it lines up with state.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign supported = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                     (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BRANCH);

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECUTER;
          OP_ITYPE:          next_state = EXECUTEI;
          OP_JAL:            next_state = JAL;
          OP_BRANCH:         next_state = BEQ;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      JAL:      next_state = ALUWB;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= state_t'(RESET_STATE);
      ctrl  <= decode_state(state_t'(RESET_STATE));
    end else begin
      state <= next_state;
      ctrl  <= decode_state(next_state);
    end
  end

  // Handshake-gated enables stay combinational so they track MemReady/Zero in the same cycle.
  assign PCWrite   = rst_n & (((state == FETCH) & MemReady) | ((state == BEQ) & Zero) | (state == JAL));
  assign IRWrite   = rst_n & (state == FETCH) & MemReady;
  assign IllegalOp = rst_n & (state == DECODE) & ~supported;

  assign AdrSrc    = ctrl.adr_src;
  assign MemWrite  = ctrl.mem_write;
  assign RegWrite  = ctrl.reg_write;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign StateOut  = state;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_JAL:    ImmSrc = 2'b10;
      OP_BRANCH: ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // funct7 only selects SUB for register-register ops; addi with bit 30 set stays ADD.
  always_comb begin
    ALUControl = 3'b000;
    case (ctrl.alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b111;
        endcase
      end
      default: ALUControl = 3'b111;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multicycle RV32I core. It replaces the single-cycle main/ALU decoder path, and lets the core share one memory port for instructions and data.
- It sequences fetch, decode, execute, memory and writeback over several clocks.
- It drives the mux selects and write enables of the shared-ALU datapath, and waits on a memory ready handshake.
- It keeps the team's ALUControl encoding.

Parameters:
- RESET_STATE, 4'd0, encoding of FETCH; the state register loads this value on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction opcode, from the instruction register
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = J, 11 = B
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, 111 invalid
- RegWrite  out  1  register file write enable
- IllegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- StateOut  out  4  current state, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0, state=FETCH and PCWrite, IRWrite, MemWrite, RegWrite and IllegalOp are forced to 0. First fetch starts on the first rising edge after rst_n deasserts.
- Outputs are Moore, decoded from state, except:
  - PCWrite (FETCH: gated by MemReady; BEQ: gated by Zero)
  - IRWrite (gated by MemReady)
  - ImmSrc and ALUControl (combinational from op/funct fields in every state)
- States use encodings 0-10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite = MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target into ALUOut). Next state by op:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> FETCH, with IllegalOp=1 for that cycle and no write enable asserted
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while MemReady=0; go to MEMWB when MemReady=1.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high for every cycle spent waiting. Next FETCH when MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (PC <- target, ALUResult = OldPC+4). Next ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero. Next FETCH.
- Defaults in any state not listed above: 0 for all selects and enables.
- ImmSrc from op: store 01, jal 10, branch 11, everything else 00.
- ALU decoder (internal ALUOp):
  - 00 -> ADD; 01 -> SUB
  - 10 with funct3=000: SUB if {op[5],funct7}=11, else ADD. addi therefore never yields SUB.
  - 10 with funct3 010 -> SLT, 110 -> OR, 111 -> AND, other funct3 -> 111
- Instruction latencies, MemReady always 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles. Each FETCH/MEMREAD/MEMWRITE wait cycle adds 1.
- Reset mid-instruction: the state returns to FETCH immediately (asynchronously), and no write enable remains asserted.
- Unknown state encodings (11-15) go to FETCH on the next edge with all enables 0.

Test Plan:
- lw, MemReady low for 2 cycles in FETCH and 1 cycle in MEMREAD -> states FETCH×3, DECODE, MEMADR, MEMREAD×2, MEMWB. IRWrite/PCWrite pulse exactly once, in the 3rd FETCH cycle. RegWrite=1, ResultSrc=01 only in MEMWB.
- sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 and AdrSrc=1 for all 4 MEMWRITE cycles. RegWrite never asserts. ImmSrc=01.
- R-type sub (funct3=000, funct7=1) -> ALUControl=001 in EXECUTER. Same fields with op=0010011 -> ALUControl=000 in EXECUTEI. funct3=110 -> 011.
- beq: Zero=1 gives PCWrite=1 in BEQ; Zero=0 gives PCWrite=0. ALUControl=001, ImmSrc=11, next state FETCH.
- jal -> DECODE, JAL (PCWrite=1, ALUSrcA=01, ALUSrcB=10), ALUWB (RegWrite=1). ImmSrc=10.
- op=1111111 -> IllegalOp=1 for 1 cycle in DECODE, then FETCH. Separately, rst_n pulsed low in MEMWRITE -> MemWrite=0 in the same cycle and StateOut=0.
